// File: rtl/fifo_line_reader_pkg.sv
// Shared types and helpers for fifo_line_reader: FSM state encoding and the
// CRC-16-CCITT byte update used when FIFO_LINE_READER_CRC_EN is defined.
package fifo_line_reader_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINE = 3'd1,
        BURST     = 3'd2,
        DRAIN     = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first, non-reflected CRC-16 update over one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/fifo_line_reader_skid.sv
// stream_skid2: 2-entry valid/ready buffer. The producer never pushes into a
// full buffer (the reader gates its FIFO reads on skid_cnt), so there is no
// in_ready. Output payload is forced to 0 while empty.
module stream_skid2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   skid_cnt
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (skid_cnt != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            if (in_valid) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
            skid_cnt <= skid_cnt + 2'(in_valid) - 2'(pop);
        end
    end

    // Payload storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk) begin
        if (in_valid) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/fifo_line_reader.sv
// fifo_line_reader: drains a sync FIFO one whole line at a time into a
// valid/ready stream with SOL/EOL markers and an idle gap between lines.
// Optional feature macro: FIFO_LINE_READER_CRC_EN (per-line CRC-16-CCITT).
module fifo_line_reader
    import fifo_line_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_LEN   = 64,
    parameter int LINE_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_en,
    input  logic [ADDR_WIDTH:0]   fifo_occupants,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sol,
    output logic                  out_eol,
    output logic [15:0]           lines_sent,
    output logic                  underrun,
    output logic [15:0]           line_crc,
    output logic                  crc_valid
);

    localparam logic [ADDR_WIDTH:0]   LINE_LEN_OCC = (ADDR_WIDTH+1)'(LINE_LEN);
    localparam logic [ADDR_WIDTH-1:0] LINE_LEN_W   = ADDR_WIDTH'(LINE_LEN);
    localparam logic [7:0]            GAP_LAST     = 8'(LINE_GAP - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] words_left;
    logic [7:0]            gap_cnt;
    logic                  inflight;
    logic                  infl_sol;
    logic                  infl_eol;
    logic [1:0]            skid_cnt;
    logic                  pop;
    logic                  eol_hs;
    logic [2:0]            room_used;

    assign pop    = out_valid && out_ready;
    assign eol_hs = pop && out_eol;

    // Words that will occupy the skid after this edge; a read is only issued
    // when its data is guaranteed a slot two cycles later.
    assign room_used = 3'(skid_cnt) + 3'(inflight) - 3'(pop);
    assign fifo_re   = !rst && (state == BURST) && (words_left != '0) && (room_used < 3'd2);

    // Line sequencing FSM; a started line always runs to its EOL handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            words_left <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_en) state <= WAIT_LINE;
                end
                WAIT_LINE: begin
                    if (fifo_occupants >= LINE_LEN_OCC) begin
                        state      <= BURST;
                        words_left <= LINE_LEN_W;
                    end else if (!line_en) begin
                        state <= IDLE;
                    end
                end
                BURST: begin
                    if (fifo_re) begin
                        words_left <= words_left - ADDR_WIDTH'(1);
                        if (words_left == ADDR_WIDTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (eol_hs) begin
                        if (LINE_GAP == 0) begin
                            state <= line_en ? WAIT_LINE : IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) state <= line_en ? WAIT_LINE : IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag each read with its line position; the data arrives one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            infl_sol <= 1'b0;
            infl_eol <= 1'b0;
        end else begin
            inflight <= fifo_re;
            infl_sol <= fifo_re && (words_left == LINE_LEN_W);
            infl_eol <= fifo_re && (words_left == ADDR_WIDTH'(1));
        end
    end

    logic [DATA_WIDTH+1:0] skid_out;

    stream_skid2 #(.W(DATA_WIDTH + 2)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight),
        .in_data   ({infl_sol, infl_eol, fifo_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out),
        .skid_cnt  (skid_cnt)
    );

    assign {out_sol, out_eol, out_data} = skid_out;

    // Line counter and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lines_sent <= 16'd0;
            underrun   <= 1'b0;
        end else begin
            if (eol_hs)               lines_sent <= lines_sent + 16'd1;
            if (fifo_re && fifo_empty) underrun  <= 1'b1;
        end
    end

`ifdef FIFO_LINE_READER_CRC_EN
    logic [15:0] crc_acc;
    logic [15:0] crc_next;

    // SOL restarts the running CRC so a line never inherits a stale value.
    always_comb begin
        crc_next = crc16_byte(out_sol ? CRC16_INIT : crc_acc, 8'(out_data));
    end

    // Running CRC over accepted words; published on the EOL handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_acc   <= CRC16_INIT;
            line_crc  <= 16'd0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= eol_hs;
            if (pop)    crc_acc  <= crc_next;
            if (eol_hs) line_crc <= crc_next;
        end
    end
`else
    assign line_crc  = 16'd0;
    assign crc_valid = 1'b0;
`endif

endmodule
